dual_ref_scheduler: RTL

Generates the two reference square waves for the double-frequency lock-in amplifier. Each wave comes from its own programmable divide-by-N counter running on the system clock. The block accepts runtime divisor updates through a valid/ready handshake and applies them only at a ref1 period boundary, so the two references restart phase-aligned. It also supplies per-period ticks and a common-boundary sync pulse to the downstream demodulators and accumulators.

---
 rtl/dual_ref_pkg.sv | 15 +
 rtl/ref_phase_counter.sv | 71 +++++++
 rtl/dual_ref_scheduler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dual_ref_pkg.sv
// dual_ref_pkg
// Shared definitions for the dual reference scheduler: the scheduler state
// encoding, the default counter width and the smallest legal divisor.
package dual_ref_pkg;

   localparam int DEF_CNT_W = 28;
   localparam int MIN_DIV   = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PENDING = 2'd2
   } state_t;

endpackage

// File: rtl/ref_phase_counter.sv
// ref_phase_counter
// One programmable divide-by-N phase counter with registered wave decode.
// Optional macro: REF_QUAD_EN adds the 90-degree shifted output `quad`.
// Ports:
//   clock_in, reset_n : clock, asynchronous active-low reset
//   divisor           : active divisor d (always >= 2)
//   clear             : force the counter back to 0 (realign)
//   run               : advance the counter; low holds counter and outputs at 0
//   counter           : current phase count 0..d-1
//   out               : square wave, high while c < d>>1
//   quad              : (REF_QUAD_EN) high while d>>2 <= c < (d>>2)+(d>>1)
//   tick              : pulse for the last cycle of the period
module ref_phase_counter
   import dual_ref_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clock_in,
   input  logic             reset_n,
   input  logic [CNT_W-1:0] divisor,
   input  logic             clear,
   input  logic             run,
   output logic [CNT_W-1:0] counter,
   output logic             out,
`ifdef REF_QUAD_EN
   output logic             quad,
`endif
   output logic             tick
);

   logic             last;
   logic [CNT_W-1:0] half;

   assign last = (counter == divisor - CNT_W'(1));
   assign half = divisor >> 1;

`ifdef REF_QUAD_EN
   logic [CNT_W-1:0] qtr;
   assign qtr = divisor >> 2;
`endif

   // Outputs are decoded from the counter value before the edge, so they
   // trail the counter by exactly one clock.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         counter <= '0;
         out     <= 1'b0;
         tick    <= 1'b0;
`ifdef REF_QUAD_EN
         quad    <= 1'b0;
`endif
      end else if (!run) begin
         counter <= '0;
         out     <= 1'b0;
         tick    <= 1'b0;
`ifdef REF_QUAD_EN
         quad    <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments let every decode below see the
         // pre-edge counter, independent of statement order.
         out     <= (counter < half);
         tick    <= last;
`ifdef REF_QUAD_EN
         quad    <= (counter >= qtr) && (counter < qtr + half);
`endif
         counter <= (clear || last) ? '0 : counter + CNT_W'(1);
      end
   end

endmodule

// File: rtl/dual_ref_scheduler.sv
// dual_ref_scheduler
// Two phase-aligned reference square waves for a double-frequency lock-in
// amplifier, with divisor updates taken over a valid/ready handshake and
// applied only at a ref1 period boundary.
// Optional macro: REF_QUAD_EN adds quadrature outputs ref1_q / ref2_q.
// Ports:
//   clock_in, reset_n      : clock, asynchronous active-low reset
//   enable                 : run the references; low returns to IDLE
//   cfg_valid/cfg_ready    : divisor pair handshake (ready low while PENDING)
//   cfg_div1, cfg_div2     : requested divisors
//   cfg_err                : one-cycle pulse when a transferred pair is < 2
//   ref1_out, ref2_out     : square waves
//   ref1_tick, ref2_tick   : last-cycle-of-period pulses
//   sync_pulse             : common boundary or realign pulse
//   ref1_q, ref2_q         : (REF_QUAD_EN) 90-degree shifted waves
//   pending                : accepted pair waiting for the ref1 boundary
module dual_ref_scheduler
   import dual_ref_pkg::*;
#(
   parameter int               CNT_W    = DEF_CNT_W,
   parameter logic [CNT_W-1:0] DIV1_RST = 28'd50,
   parameter logic [CNT_W-1:0] DIV2_RST = 28'd100
) (
   input  logic             clock_in,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_div1,
   input  logic [CNT_W-1:0] cfg_div2,
   output logic             cfg_err,
   output logic             ref1_out,
   output logic             ref2_out,
   output logic             ref1_tick,
   output logic             ref2_tick,
   output logic             sync_pulse,
`ifdef REF_QUAD_EN
   output logic             ref1_q,
   output logic             ref2_q,
`endif
   output logic             pending
);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] d1, d2, s1, s2, c1, c2;
   logic             transfer, bad, accept;
   logic             at_end1, at_end2, realign, commit;
   logic             direct_load, shadow_load;

   assign transfer = cfg_valid && cfg_ready;
   assign bad      = (cfg_div1 < CNT_W'(MIN_DIV)) || (cfg_div2 < CNT_W'(MIN_DIV));
   assign accept   = transfer && !bad;

   assign at_end1  = (c1 == d1 - CNT_W'(1));
   assign at_end2  = (c2 == d2 - CNT_W'(1));

   // A pending shadow lands either at the ref1 boundary or, when enable
   // drops, straight away so the next start uses the new pair.
   assign realign  = (state == PENDING) && enable && at_end1;
   assign commit   = (state == PENDING) && (!enable || at_end1);

   // While stopped (IDLE, or enable falling this cycle) there is no phase to
   // preserve, so an accepted pair goes directly to the active divisors.
   assign direct_load = accept && ((state == IDLE) || !enable);
   assign shadow_load = accept && (state == RUN) && enable;

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_nxt; no latch.
      state_nxt = state;
      unique case (state)
         IDLE:    if (enable) state_nxt = RUN;
         RUN:     if (!enable)         state_nxt = IDLE;
                  else if (accept)     state_nxt = PENDING;
         PENDING: if (!enable)         state_nxt = IDLE;
                  else if (at_end1)    state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cfg_ready = (state != PENDING);
      pending   = (state == PENDING);
   end

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         d1         <= DIV1_RST;
         d2         <= DIV2_RST;
         // NOTE: shadows are reset too; a stale shadow must never commit.
         s1         <= '0;
         s2         <= '0;
         cfg_err    <= 1'b0;
         sync_pulse <= 1'b0;
      end else begin
         cfg_err    <= transfer && bad;
         sync_pulse <= enable && at_end1 && (at_end2 || (state == PENDING));
         if (commit) begin
            d1 <= s1;
            d2 <= s2;
         end else if (direct_load) begin
            d1 <= cfg_div1;
            d2 <= cfg_div2;
         end
         if (shadow_load) begin
            s1 <= cfg_div1;
            s2 <= cfg_div2;
         end
      end
   end

   ref_phase_counter #(.CNT_W(CNT_W)) u_ref1 (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .divisor  (d1),
      .clear    (realign),
      .run      (enable),
      .counter  (c1),
      .out      (ref1_out),
`ifdef REF_QUAD_EN
      .quad     (ref1_q),
`endif
      .tick     (ref1_tick)
   );

   ref_phase_counter #(.CNT_W(CNT_W)) u_ref2 (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .divisor  (d2),
      .clear    (realign),
      .run      (enable),
      .counter  (c2),
      .out      (ref2_out),
`ifdef REF_QUAD_EN
      .quad     (ref2_q),
`endif
      .tick     (ref2_tick)
   );

endmodule
